// File: rtl/dot_product_sequencer.sv
// Control FSM for one dot-product pass: clears the engine, streams ceil(NOE/NI)
// operand packages from row memory, then captures the engine result or times out.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; base address latched on acceptance
// S_CLEAR | one-cycle engine_clear pulse
// S_ISSUE | one read address per cycle, base+k for k = 0..NPKG-1
// S_WAIT  | waiting for engine_finish, bounded by TIMEOUT cycles
// S_DONE  | one-cycle done pulse, then back to S_IDLE
module dot_product_sequencer #(
   parameter int NOE     = 10,
   parameter int NI      = 8,
   parameter int ADDR_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              pkg_valid,
   output logic              pkg_last,
   output logic              engine_clear,
   input  logic              engine_finish,
   input  logic [31:0]       engine_result,
   output logic [31:0]       result,
   output logic              done,
   output logic              err
);

   localparam int NPKG = (NOE + NI - 1) / NI;
   localparam int KW   = $clog2(NPKG + 1);
   localparam int TW   = $clog2(TIMEOUT + 1);
   localparam logic [KW-1:0] K_LAST = KW'(NPKG - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_ISSUE, S_WAIT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [KW-1:0]       k_q, k_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic [31:0]         result_q, result_d;
   logic                err_q, err_d;
   logic                busy_q, busy_d;
   logic                rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                pkg_valid_q, pkg_valid_d;
   logic                pkg_last_q, pkg_last_d;
   logic                engine_clear_q, engine_clear_d;
   logic                done_q, done_d;

   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      k_d      = k_q;
      tmo_d    = tmo_q;
      result_d = result_q;
      err_d    = err_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               err_d   = 1'b0;
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            k_d     = '0;
            state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (k_q == K_LAST) begin
               tmo_d   = '0;
               state_d = S_WAIT;
            end else begin
               k_d = k_q + KW'(1);
            end
         end
         S_WAIT: begin
            // finish has priority over an expiring timeout in the same cycle
            if (engine_finish) begin
               result_d = engine_result;
               state_d  = S_DONE;
            end else if (tmo_q == T_LAST) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // outputs are registered, so they are derived from the next state
      busy_d         = (state_d != S_IDLE);
      engine_clear_d = (state_d == S_CLEAR);
      rd_en_d        = (state_d == S_ISSUE);
      rd_addr_d      = rd_en_d ? (base_d + ADDR_W'(k_d)) : rd_addr_q;
      pkg_valid_d    = rd_en_q;
      pkg_last_d     = rd_en_q && (k_q == K_LAST);
      done_d         = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= S_IDLE;
         base_q         <= '0;
         k_q            <= '0;
         tmo_q          <= '0;
         result_q       <= '0;
         err_q          <= 1'b0;
         busy_q         <= 1'b0;
         rd_en_q        <= 1'b0;
         rd_addr_q      <= '0;
         pkg_valid_q    <= 1'b0;
         pkg_last_q     <= 1'b0;
         engine_clear_q <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         k_q            <= k_d;
         tmo_q          <= tmo_d;
         result_q       <= result_d;
         err_q          <= err_d;
         busy_q         <= busy_d;
         rd_en_q        <= rd_en_d;
         rd_addr_q      <= rd_addr_d;
         pkg_valid_q    <= pkg_valid_d;
         pkg_last_q     <= pkg_last_d;
         engine_clear_q <= engine_clear_d;
         done_q         <= done_d;
      end
   end

   assign busy         = busy_q;
   assign rd_en        = rd_en_q;
   assign rd_addr      = rd_addr_q;
   assign pkg_valid    = pkg_valid_q;
   assign pkg_last     = pkg_last_q;
   assign engine_clear = engine_clear_q;
   assign done         = done_q;
   assign err          = err_q;
   assign result       = result_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: four package-count configurations
// share stimulus; instance 0 (NOE=10, NI=8, TIMEOUT=8) is scoreboarded in detail.
module tb_dot_product_sequencer;

   localparam int ND = 4;
   localparam int NOE_T [ND]  = '{10, 16, 17, 8};
   localparam int NI_T  [ND]  = '{8, 8, 16, 8};
   localparam int NPKG_T[ND]  = '{2, 2, 2, 1};

   logic        clk = 1'b0;
   logic        reset, start, engine_finish;
   logic [7:0]  base_addr;
   logic [31:0] engine_result;

   logic        busy_w[ND], rd_en_w[ND], pkg_valid_w[ND], pkg_last_w[ND];
   logic        engine_clear_w[ND], done_w[ND], err_w[ND];
   logic [7:0]  rd_addr_w[ND];
   logic [31:0] result_w[ND];

   always #5 clk = ~clk;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      dot_product_sequencer #(
         .NOE(NOE_T[g]), .NI(NI_T[g]), .ADDR_W(8), .TIMEOUT(8)
      ) u_dut (
         .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
         .busy(busy_w[g]), .rd_en(rd_en_w[g]), .rd_addr(rd_addr_w[g]),
         .pkg_valid(pkg_valid_w[g]), .pkg_last(pkg_last_w[g]),
         .engine_clear(engine_clear_w[g]), .engine_finish(engine_finish),
         .engine_result(engine_result), .result(result_w[g]),
         .done(done_w[g]), .err(err_w[g])
      );
   end

   typedef struct { logic [31:0] res; logic err; } res_t;
   typedef struct { logic [7:0] base; int fin; logic [31:0] eres; } vec_t;

   logic [7:0]  addr_q[$];
   res_t        res_q[$];
   int          n_vec = 0, n_err = 0, cyc = 0;
   int          pkg_cnt[ND], pv_cnt[ND];
   logic [31:0] last_result;
   vec_t        tbl[7];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(string name);
      n_vec++;
      n_err++;
      $display("FAIL %s: pulse with nothing expected (cycle %0d)", name, cyc);
   endtask

   // advance one cycle, then run the per-cycle monitors
   task automatic tick();
      res_t r;
      @(posedge clk);
      #1;
      cyc++;
      for (int g = 0; g < ND; g++) begin
         if (engine_clear_w[g] === 1'b1) begin
            pkg_cnt[g] = 0;
            pv_cnt[g]  = 0;
         end
         if (rd_en_w[g] === 1'b1) pkg_cnt[g]++;
         if (pkg_valid_w[g] === 1'b1) pv_cnt[g]++;
         if (pkg_last_w[g] === 1'b1) begin
            check($sformatf("pkg_last_pos[%0d]", g), pv_cnt[g], NPKG_T[g]);
            check($sformatf("pkg_last_valid[%0d]", g), {31'b0, pkg_valid_w[g]}, 1);
         end
         if (done_w[g] === 1'b1)
            check($sformatf("rd_en_count[%0d]", g), pkg_cnt[g], NPKG_T[g]);
      end
      if (rd_en_w[0] === 1'b1) begin
         if (addr_q.size() == 0) unexpected("rd_en");
         else check("rd_addr", {24'b0, rd_addr_w[0]}, {24'b0, addr_q.pop_front()});
      end
      if (done_w[0] === 1'b1) begin
         if (res_q.size() == 0) unexpected("done");
         else begin
            r = res_q.pop_front();
            check("result", result_w[0], r.res);
            check("err", {31'b0, err_w[0]}, {31'b0, r.err});
         end
      end
   endtask

   task automatic expect_op(logic [7:0] base, logic [31:0] res, logic e);
      res_t r;
      addr_q.push_back(base);
      addr_q.push_back(base + 8'd1);
      r.res = res;
      r.err = e;
      res_q.push_back(r);
   endtask

   task automatic check_all_zero(string tag);
      check({tag, "_busy"},  {31'b0, busy_w[0]}, 0);
      check({tag, "_rd_en"}, {31'b0, rd_en_w[0]}, 0);
      check({tag, "_rd_addr"}, {24'b0, rd_addr_w[0]}, 0);
      check({tag, "_pkg_valid"}, {31'b0, pkg_valid_w[0]}, 0);
      check({tag, "_pkg_last"}, {31'b0, pkg_last_w[0]}, 0);
      check({tag, "_clear"}, {31'b0, engine_clear_w[0]}, 0);
      check({tag, "_done"}, {31'b0, done_w[0]}, 0);
      check({tag, "_err"}, {31'b0, err_w[0]}, 0);
      check({tag, "_result"}, result_w[0], 0);
   endtask

   // fin = cycle (after start) at which finish is sampled; 0 means never
   task automatic run_op(logic [7:0] base, int fin, logic [31:0] eres);
      logic got;
      if (fin != 0) begin
         expect_op(base, eres, 1'b0);
         last_result = eres;
      end else begin
         expect_op(base, last_result, 1'b1);
      end
      base_addr     = base;
      engine_result = eres;
      start         = 1'b1;
      tick();
      start = 1'b0;
      check("op_clear", {31'b0, engine_clear_w[0]}, 1);
      check("op_err_cleared", {31'b0, err_w[0]}, 0);
      got = 1'b0;
      for (int c = 1; c < 40 && !got; c++) begin
         engine_finish = (fin != 0) && (c == fin);
         tick();
         if (done_w[0] === 1'b1) begin
            got = 1'b1;
            check("done_cycle", c + 1, (fin != 0) ? fin + 1 : 12);
         end
      end
      engine_finish = 1'b0;
      if (!got) unexpected("op_no_done_within_bound");
      tick();
   endtask

   initial begin
      int nc, nd, ni;
      tbl[0] = '{8'h60, 0,  32'h0000_0000};
      tbl[1] = '{8'h20, 4,  32'h3F80_0000};
      tbl[2] = '{8'hFF, 6,  32'hC049_0FDB};
      tbl[3] = '{8'h40, 0,  32'hDEAD_BEEF};
      tbl[4] = '{8'h80, 11, 32'h4228_0000};
      tbl[5] = '{8'h7F, 0,  32'h1111_1111};
      tbl[6] = '{8'h01, 5,  32'h0000_0000};

      reset = 1'b1; start = 1'b0; engine_finish = 1'b0;
      base_addr = 8'h00; engine_result = 32'h0; last_result = 32'h0;
      tick();
      tick();
      check_all_zero("rst");
      reset = 1'b0;
      tick();

      // cycle-exact single operation
      expect_op(8'h10, 32'h4120_0000, 1'b0);
      last_result   = 32'h4120_0000;
      base_addr     = 8'h10;
      engine_result = 32'h4120_0000;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t1_clear_c1", {31'b0, engine_clear_w[0]}, 1);
      check("t1_busy_c1", {31'b0, busy_w[0]}, 1);
      tick();
      check("t1_rd_en_c2", {31'b0, rd_en_w[0]}, 1);
      check("t1_addr_c2", {24'b0, rd_addr_w[0]}, 32'h10);
      tick();
      check("t1_addr_c3", {24'b0, rd_addr_w[0]}, 32'h11);
      check("t1_last_c3", {31'b0, pkg_last_w[0]}, 0);
      tick();
      check("t1_last_c4", {31'b0, pkg_last_w[0]}, 1);
      check("t1_valid_c4", {31'b0, pkg_valid_w[0]}, 1);
      check("t1_rd_en_c4", {31'b0, rd_en_w[0]}, 0);
      repeat (5) tick();
      check("t1_done_c9", {31'b0, done_w[0]}, 0);
      engine_finish = 1'b1;
      tick();
      engine_finish = 1'b0;
      check("t1_done_c10", {31'b0, done_w[0]}, 1);
      check("t1_result_c10", result_w[0], 32'h4120_0000);
      tick();
      check("t1_idle_c11", {31'b0, busy_w[0]}, 0);
      tick();

      // start held high: exactly one op per IDLE visit, one IDLE cycle between ops
      for (int i = 0; i < 3; i++) expect_op(8'h30, 32'h1234_5678, 1'b0);
      last_result   = 32'h1234_5678;
      base_addr     = 8'h30;
      engine_result = 32'h1234_5678;
      start = 1'b1;
      engine_finish = 1'b1;
      nc = 0; nd = 0; ni = 0;
      for (int c = 1; c <= 17; c++) begin
         tick();
         nc += int'(engine_clear_w[0]);
         nd += int'(done_w[0]);
         ni += int'(!busy_w[0]);
      end
      tick();
      start = 1'b0;
      engine_finish = 1'b0;
      check("cont_clears", nc, 3);
      check("cont_dones", nd, 3);
      check("cont_idle_cycles", ni, 2);
      check("cont_idle_c18", {31'b0, busy_w[0]}, 0);
      repeat (12) tick();

      // reset mid-ISSUE aborts without done and clears result
      addr_q.push_back(8'h50);
      addr_q.push_back(8'h51);
      base_addr = 8'h50;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      last_result = 32'h0;
      check_all_zero("midrst");
      engine_finish = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("midrst_no_done", {31'b0, done_w[0]}, 0);
         check("midrst_idle", {31'b0, busy_w[0]}, 0);
      end
      engine_finish = 1'b0;
      tick();

      for (int i = 0; i < 7; i++) run_op(tbl[i].base, tbl[i].fin, tbl[i].eres);

      check("sb_addr_left", addr_q.size(), 0);
      check("sb_res_left", res_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
